// File: rtl/multiply_if.sv
// Control/register-file side bundle of the iterative multiplier: request inputs,
// write-back outputs and condition flags.
interface multiply_if #(
    parameter int WIDTH     = 32,
    parameter int SEL_WIDTH = 4
);
    logic                 start;
    logic                 accumulate;
    logic                 set_flags;
    logic [WIDTH-1:0]     port_a;
    logic [WIDTH-1:0]     port_b;
    logic [WIDTH-1:0]     acc_value;
    logic [SEL_WIDTH-1:0] dest_select;
    logic                 busy;
    logic                 done;
    logic [WIDTH-1:0]     port_c;
    logic [SEL_WIDTH-1:0] decoder_control;
    logic                 load_enable;
    logic                 n_flag;
    logic                 z_flag;

    modport master (
        output start, accumulate, set_flags, port_a, port_b, acc_value, dest_select,
        input  busy, done, port_c, decoder_control, load_enable, n_flag, z_flag
    );

    modport slave (
        input  start, accumulate, set_flags, port_a, port_b, acc_value, dest_select,
        output busy, done, port_c, decoder_control, load_enable, n_flag, z_flag
    );
endinterface

// File: rtl/multiply_unit.sv
// Iterative shift-add multiplier (MUL / MLA), low WIDTH bits of the result written
// back to the register file after a fixed WIDTH-iteration run.
module multiply_unit #(
    parameter int WIDTH     = 32,
    parameter int SEL_WIDTH = 4
) (
    input logic        clk,
    input logic        reset,
    multiply_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, MUL, WRITE} state_t;

    state_t               state;
    logic [WIDTH-1:0]     mcand;
    logic [WIDTH-1:0]     mplier;
    logic [WIDTH-1:0]     product;
    logic [CW-1:0]        count;
    logic [SEL_WIDTH-1:0] dest;
    logic                 flags_en;
    logic [WIDTH-1:0]     prod_next;

    assign prod_next = product + (mplier[0] ? mcand : '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state               <= IDLE;
            mcand               <= '0;
            mplier              <= '0;
            product             <= '0;
            count               <= '0;
            dest                <= '0;
            flags_en            <= 1'b0;
            bus.busy            <= 1'b0;
            bus.done            <= 1'b0;
            bus.load_enable     <= 1'b0;
            bus.port_c          <= '0;
            bus.decoder_control <= '0;
            bus.n_flag          <= 1'b0;
            bus.z_flag          <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        mcand    <= bus.port_a;
                        mplier   <= bus.port_b;
                        dest     <= bus.dest_select;
                        flags_en <= bus.set_flags;
                        product  <= bus.accumulate ? bus.acc_value : '0;
                        count    <= '0;
                        bus.busy <= 1'b1;
                        state    <= MUL;
                    end
                end
                MUL: begin
                    product <= prod_next;
                    mcand   <= mcand << 1;
                    mplier  <= mplier >> 1;
                    count   <= count + 1'b1;
                    // Final iteration: publish the result so it is stable for all of WRITE.
                    if (count == CW'(WIDTH - 1)) begin
                        bus.port_c          <= prod_next;
                        bus.decoder_control <= dest;
                        bus.load_enable     <= 1'b1;
                        bus.done            <= 1'b1;
                        state               <= WRITE;
                    end
                end
                WRITE: begin
                    bus.load_enable <= 1'b0;
                    bus.done        <= 1'b0;
                    bus.busy        <= 1'b0;
                    if (flags_en) begin
                        bus.n_flag <= product[WIDTH-1];
                        bus.z_flag <= (product == '0);
                    end
                    state <= IDLE;
                end
                default: begin
                    bus.load_enable <= 1'b0;
                    bus.done        <= 1'b0;
                    bus.busy        <= 1'b0;
                    state           <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_multiply_unit.sv
// Directed-vector bench for multiply_unit: table of operations plus hand-written
// reset-abort sequence.
module tb_multiply_unit;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   pass_cnt = 0;
    int   total_cnt = 0;

    always #5 clk = ~clk;

    multiply_if #(.WIDTH(32), .SEL_WIDTH(4)) bus ();
    multiply_unit #(.WIDTH(32), .SEL_WIDTH(4)) dut (.clk(clk), .reset(reset), .bus(bus));

    typedef struct {
        string       name;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] acc;
        logic        accum;
        logic [3:0]  dest;
        logic        sf;
        int          extra_at;   // edge index at which a spurious start is sampled (0 = none)
        logic [31:0] exp_c;
        logic        exp_n;
        logic        exp_z;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    task automatic run_op(input vec_t v);
        int le_cnt, first_le, busy_gap;
        logic [31:0] c_got;
        logic [3:0]  d_got;
        logic        done_got, busy_after, n_got, z_got;
        le_cnt = 0; first_le = -1; busy_gap = 0;
        c_got = '0; d_got = '0; done_got = 1'b0; busy_after = 1'b1; n_got = 1'b0; z_got = 1'b0;
        @(negedge clk);
        bus.port_a = v.a; bus.port_b = v.b; bus.acc_value = v.acc;
        bus.accumulate = v.accum; bus.dest_select = v.dest; bus.set_flags = v.sf;
        bus.start = 1'b1;
        @(posedge clk);                       // E0
        for (int n = 1; n <= 36; n++) begin
            @(negedge clk);
            bus.start = (v.extra_at == n);
            if (n == 1) begin                 // captured copies must be used from here on
                bus.port_a = $urandom; bus.port_b = $urandom; bus.acc_value = $urandom;
                bus.accumulate = ~v.accum; bus.dest_select = ~v.dest; bus.set_flags = ~v.sf;
            end
            @(posedge clk);
            #1;
            if (bus.load_enable) begin
                le_cnt++;
                if (first_le < 0) begin
                    first_le = n; c_got = bus.port_c; d_got = bus.decoder_control; done_got = bus.done;
                end
            end
            if (n <= 32 && !bus.busy) busy_gap = 1;
            if (n == 33) begin
                busy_after = bus.busy; n_got = bus.n_flag; z_got = bus.z_flag;
            end
        end
        chk({v.name, " le_count"}, le_cnt, 1);
        chk({v.name, " latency"}, first_le, 32);
        chk({v.name, " port_c"}, c_got, v.exp_c);
        chk({v.name, " decoder_control"}, {28'd0, d_got}, {28'd0, v.dest});
        chk({v.name, " done"}, {31'd0, done_got}, 32'd1);
        chk({v.name, " busy_gap"}, busy_gap, 0);
        chk({v.name, " busy_after"}, {31'd0, busy_after}, 32'd0);
        chk({v.name, " n_flag"}, {31'd0, n_got}, {31'd0, v.exp_n});
        chk({v.name, " z_flag"}, {31'd0, z_got}, {31'd0, v.exp_z});
    endtask

    initial begin
        int le_seen;
        vecs[0] = '{"mul3x5",    32'd3,          32'd5,          32'd0,   1'b0, 4'd2,  1'b1, 0,  32'd15,         1'b0, 1'b0};
        vecs[1] = '{"mul_ones",  32'hFFFFFFFF,   32'hFFFFFFFF,   32'd0,   1'b0, 4'd7,  1'b1, 0,  32'h00000001,   1'b0, 1'b0};
        vecs[2] = '{"mla",       32'd6,          32'd7,          32'd100, 1'b1, 4'd10, 1'b1, 0,  32'd142,        1'b0, 1'b0};
        vecs[3] = '{"zero",      32'd0,          32'd1234,       32'd0,   1'b0, 4'd3,  1'b1, 0,  32'd0,          1'b0, 1'b1};
        vecs[4] = '{"noflags",   32'd1,          32'd1234,       32'd0,   1'b0, 4'd4,  1'b0, 0,  32'd1234,       1'b0, 1'b1};
        vecs[5] = '{"signed",    32'hFFFFFFFE,   32'd3,          32'd0,   1'b0, 4'd5,  1'b1, 10, 32'hFFFFFFFA,   1'b1, 1'b0};
        vecs[6] = '{"wrap_hi",   32'h00010000,   32'h00010000,   32'd0,   1'b0, 4'd15, 1'b1, 33, 32'd0,          1'b0, 1'b1};
        vecs[7] = '{"mla_wrap",  32'hFFFFFFFF,   32'd1,          32'd2,   1'b1, 4'd1,  1'b1, 0,  32'd1,          1'b0, 1'b0};

        bus.start = 1'b0; bus.accumulate = 1'b0; bus.set_flags = 1'b0;
        bus.port_a = '0; bus.port_b = '0; bus.acc_value = '0; bus.dest_select = '0;
        repeat (3) @(posedge clk);
        @(negedge clk); reset = 1'b0;
        chk("rst busy", {31'd0, bus.busy}, 32'd0);
        chk("rst done", {31'd0, bus.done}, 32'd0);
        chk("rst load_enable", {31'd0, bus.load_enable}, 32'd0);
        chk("rst port_c", bus.port_c, 32'd0);
        chk("rst decoder_control", {28'd0, bus.decoder_control}, 32'd0);
        chk("rst n_flag", {31'd0, bus.n_flag}, 32'd0);
        chk("rst z_flag", {31'd0, bus.z_flag}, 32'd0);

        foreach (vecs[i]) run_op(vecs[i]);   // flags after "signed": n=1, z=0

        // Abort: start at E0, reset sampled at E15.
        le_seen = 0;
        @(negedge clk);
        bus.port_a = 32'd9; bus.port_b = 32'd9; bus.accumulate = 1'b0; bus.set_flags = 1'b1;
        bus.dest_select = 4'd6; bus.start = 1'b1;
        @(posedge clk);                       // E0
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            bus.start = 1'b0;
            reset = (n == 15);
            @(posedge clk);
            #1;
            if (bus.load_enable) le_seen++;
            if (n == 14) chk("abort busy_before", {31'd0, bus.busy}, 32'd1);
            if (n == 15) begin
                chk("abort busy", {31'd0, bus.busy}, 32'd0);
                chk("abort port_c", bus.port_c, 32'd0);
                chk("abort n_flag", {31'd0, bus.n_flag}, 32'd0);
            end
        end
        chk("abort no_load_enable", le_seen, 0);
        @(negedge clk); reset = 1'b0;

        run_op('{"after_abort", 32'd11, 32'd13, 32'd0, 1'b0, 4'd8, 1'b1, 0, 32'd143, 1'b0, 1'b0});

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
